// File: rtl/hazard_if.sv
// Signal bundle between the ID stage (master) and the hazard unit (slave).
// The master drives decode/EX information and receives stall/flush/halt control.
interface hazard_if;
    logic [3:0] op_code;
    logic [3:0] op1;
    logic [3:0] op2;
    logic [3:0] op2_ex;
    logic [3:0] mem_read;
    logic [1:0] branch;
    logic [2:0] hazard;
    logic       if_write;
    logic       pc_write;

    modport master (
        output op_code, op1, op2, op2_ex, mem_read, branch,
        input  hazard, if_write, pc_write
    );

    modport slave (
        input  op_code, op1, op2, op2_ex, mem_read, branch,
        output hazard, if_write, pc_write
    );
endinterface

// File: rtl/hazard_unit.sv
// Load-use stall, branch/jump flush and sticky halt for the 16-bit MIPS-style pipeline.
// Outputs are combinational from the ID/EX inputs plus the stall_q and halted_q state bits.
module hazard_unit (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hz
);
    localparam logic [3:0] OP_ALU    = 4'h0;
    localparam logic [3:0] OP_STORE  = 4'h9;
    localparam logic [3:0] OP_BEQ    = 4'hA;
    localparam logic [3:0] OP_BNE    = 4'hB;
    localparam logic [3:0] OP_JUMP   = 4'hE;
    localparam logic [3:0] OP_HALT   = 4'hF;
    localparam logic [3:0] MEM_WORD  = 4'h1;
    localparam logic [3:0] MEM_BYTE  = 4'h2;
    localparam logic [1:0] BR_TAKEN  = 2'b01;
    localparam logic [1:0] BR_JUMP   = 2'b10;

    logic stall_q, stall_d;
    logic halted_q, halted_d;
    logic usesOp1, usesOp2, isLoad, dep;
    logic stallNow, flushNow, haltNow;

    always_comb begin
        usesOp1  = (hz.op_code != OP_JUMP) && (hz.op_code != OP_HALT);
        usesOp2  = (hz.op_code == OP_ALU) || (hz.op_code == OP_STORE) ||
                   (hz.op_code == OP_BEQ) || (hz.op_code == OP_BNE);
        isLoad   = (hz.mem_read == MEM_WORD) || (hz.mem_read == MEM_BYTE);
        // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
        dep      = (hz.op2_ex != 4'h0) &&
                   ((usesOp1 && (hz.op1 == hz.op2_ex)) ||
                    (usesOp2 && (hz.op2 == hz.op2_ex)));
        stallNow = isLoad && dep && !stall_q;
        haltNow  = (hz.op_code == OP_HALT);
        flushNow = ((hz.branch == BR_TAKEN) || (hz.branch == BR_JUMP)) &&
                   !stallNow && !halted_q;
        stall_d  = stallNow;
        halted_d = halted_q || haltNow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            stall_q  <= stall_d;
            halted_q <= halted_d;
        end
    end

    // Priority: reset override, halt, stall, flush, then normal flow.
    always_comb begin
        hz.hazard   = 3'b000;
        hz.if_write = 1'b1;
        hz.pc_write = 1'b1;
        if (rst) begin
            hz.hazard   = 3'b000;
        end else if (halted_q || haltNow) begin
            hz.hazard   = 3'b100;
            hz.if_write = 1'b0;
            hz.pc_write = 1'b0;
        end else if (stallNow) begin
            hz.hazard   = 3'b001;
            hz.if_write = 1'b0;
            hz.pc_write = 1'b0;
        end else if (flushNow) begin
            hz.hazard   = 3'b010;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized cycles
// compared against a rule-level reference model of stall, flush and halt.
module tb_hazard_unit;
    logic clk = 1'b0;
    logic rst;
    int   testsRun = 0;
    int   testsFailed = 0;
    logic mStallQ = 1'b0;
    logic mHaltedQ = 1'b0;

    hazard_if bus ();

    hazard_unit dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    always #5 clk = ~clk;

    // Reference: a load-use stall needs a real load whose destination is a register the ID instruction reads.
    function automatic logic modelStall(input logic stallQ);
        logic isLoad, readsOp1, readsOp2, dep;
        isLoad   = (bus.mem_read inside {4'h1, 4'h2});
        readsOp1 = !(bus.op_code inside {4'hE, 4'hF});
        readsOp2 = (bus.op_code inside {4'h0, 4'h9, 4'hA, 4'hB});
        dep      = (bus.op2_ex != 4'h0) &&
                   ((readsOp1 && bus.op1 == bus.op2_ex) || (readsOp2 && bus.op2 == bus.op2_ex));
        return isLoad && dep && !stallQ;
    endfunction

    // Expected {hazard, if_write, pc_write}.
    function automatic logic [4:0] modelOut();
        if (rst) return 5'b00011;
        if (mHaltedQ || bus.op_code == 4'hF) return 5'b10000;
        if (modelStall(mStallQ)) return 5'b00100;
        if (bus.branch == 2'b01 || bus.branch == 2'b10) return 5'b01011;
        return 5'b00011;
    endfunction

    function automatic logic [4:0] dutOut();
        return {bus.hazard, bus.if_write, bus.pc_write};
    endfunction

    task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got hazard/if/pc=%b expected %b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] opc, input logic [3:0] o1, input logic [3:0] o2,
                                 input logic [3:0] o2ex, input logic [3:0] mr, input logic [1:0] br);
        bus.op_code  = opc;
        bus.op1      = o1;
        bus.op2      = o2;
        bus.op2_ex   = o2ex;
        bus.mem_read = mr;
        bus.branch   = br;
        #1;
    endtask

    // Advance one clock, updating the model state from the inputs held across the edge.
    task automatic tick();
        logic nS, nH;
        nS = rst ? 1'b0 : modelStall(mStallQ);
        nH = rst ? 1'b0 : (mHaltedQ || bus.op_code == 4'hF);
        @(posedge clk);
        mStallQ  = nS;
        mHaltedQ = nH;
        #1;
    endtask

    initial begin
        logic [3:0] memCodes [5];
        logic [3:0] opc;
        memCodes[0] = 4'h0; memCodes[1] = 4'h1; memCodes[2] = 4'h2;
        memCodes[3] = 4'hF; memCodes[4] = 4'h3;

        rst = 1'b1;
        applyStimulus(4'hF, 4'h1, 4'h1, 4'h1, 4'h1, 2'b01);
        checkOutput("resetForced", dutOut(), 5'b00011);
        tick();
        rst = 1'b0;

        applyStimulus(4'h0, 4'hF, 4'hC, 4'hF, 4'hF, 2'b00);
        checkOutput("noLoad1", dutOut(), 5'b00011);
        applyStimulus(4'h0, 4'hF, 4'hA, 4'h5, 4'h0, 2'b00);
        checkOutput("noLoad2", dutOut(), 5'b00011);

        applyStimulus(4'h0, 4'hF, 4'h0, 4'hF, 4'h1, 2'b00);
        checkOutput("loadUse", dutOut(), 5'b00100);
        tick();
        checkOutput("stallOnce", dutOut(), 5'b00011);
        tick();
        applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 2'b00);
        checkOutput("zeroReg", dutOut(), 5'b00011);
        applyStimulus(4'h4, 4'h3, 4'h7, 4'h7, 4'h1, 2'b00);
        checkOutput("op2Unused", dutOut(), 5'b00011);
        applyStimulus(4'h0, 4'h1, 4'h2, 4'h2, 4'h2, 2'b00);
        checkOutput("byteLoadOp2", dutOut(), 5'b00100);
        tick();

        applyStimulus(4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 2'b01);
        checkOutput("flushBranch", dutOut(), 5'b01011);
        tick();
        applyStimulus(4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 2'b10);
        checkOutput("flushJump", dutOut(), 5'b01011);
        applyStimulus(4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 2'b11);
        checkOutput("reservedBr", dutOut(), 5'b00011);
        applyStimulus(4'h0, 4'h3, 4'h2, 4'h3, 4'h1, 2'b01);
        checkOutput("stallBeatsBr", dutOut(), 5'b00100);
        tick();
        checkOutput("brAfterStall", dutOut(), 5'b01011);
        tick();

        applyStimulus(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00);
        checkOutput("haltNow", dutOut(), 5'b10000);
        tick();
        applyStimulus(4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 2'b01);
        checkOutput("haltSticky", dutOut(), 5'b10000);
        tick();
        checkOutput("haltSticky2", dutOut(), 5'b10000);

        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncReset", dutOut(), 5'b00011);
        mStallQ  = 1'b0;
        mHaltedQ = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("afterReset", dutOut(), 5'b01011);
        tick();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                #1;
                checkOutput("rndReset", dutOut(), 5'b00011);
                mStallQ  = 1'b0;
                mHaltedQ = 1'b0;
                rst = 1'b0;
            end
            opc = ($urandom_range(0, 24) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            applyStimulus(opc, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                          4'($urandom_range(0, 3)), memCodes[$urandom_range(0, 4)],
                          2'($urandom_range(0, 3)));
            checkOutput("random", dutOut(), modelOut());
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard detection unit for the 16-bit MIPS-style CPU, sitting between the ID stage and the IF/ID and PC write-enable logic. It compares ID-stage source registers against the destination of a load in EX and raises a one-cycle load-use stall. It raises an IF/ID flush on taken branches and jumps, and latches a sticky halt. Module name: `hazard_unit`.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; asynchronous, active-high.
- op_code  in  4  opcode of the instruction in ID.
- op1  in  4  ID source register 1 number.
- op2  in  4  ID source register 2 number.
- op2_ex  in  4  destination register number of the instruction in EX.
- mem_read  in  4  EX memory-read code: 4'h1 = word load, 4'h2 = byte load, any other value = no load.
- branch  in  2  ID branch resolution: 00 = none/not taken, 01 = taken branch, 10 = jump, 11 = reserved (treated as 00).
- hazard  out  3  control bits:
  - [0] stall: zero the ID/EX control signals (insert a bubble).
  - [1] flush: IF/ID becomes a nop.
  - [2] halt.
- if_write  out  1  IF/ID register write enable, active-high.
- pc_write  out  1  PC write enable, active-high.

## Operation
Operand usage by op_code:
- uses_op1 = 1 unless op_code is 4'hE (jump) or 4'hF (halt).
- uses_op2 = 1 only for op_code 4'h0 (ALU R-type), 4'h9 (store), 4'hA and 4'hB (branches).

Register 4'h0 is hardwired zero and never causes a hazard.

Load-use condition:
- is_load = (mem_read == 4'h1) or (mem_read == 4'h2).
- dep = (uses_op1 and op1 == op2_ex) or (uses_op2 and op2 == op2_ex), with op2_ex != 0.
- stall = is_load and dep and not stall_q.

Flush: flush = (branch == 01 or branch == 10) and not stall and not halted.

Halt: halt_now = (op_code == 4'hF). The `halted` register sets on the first clock edge where halt_now is true and stays set until rst.

Priority, highest first:
1. halted or halt_now: hazard = 3'b100, if_write = 0, pc_write = 0.
2. stall: hazard = 3'b001, if_write = 0, pc_write = 0.
3. flush: hazard = 3'b010, if_write = 1, pc_write = 1.
4. Otherwise: hazard = 3'b000, if_write = 1, pc_write = 1.

Unknown (X) inputs on op_code or branch may propagate X to outputs. No further requirement applies to X inputs.

## Timing
- Outputs are combinational from the current inputs and the two state bits `stall_q` and `halted`, so there is zero latency within the cycle.
- stall_q <= stall on each rising edge. This guarantees one load-use stall lasts exactly one cycle even if the inputs do not change, because EX holds a bubble on the next cycle.
- halted is sticky from the edge after halt_now is first seen.
- Reset (async, active-high): stall_q = 0 and halted = 0 immediately. While rst is high, outputs are forced to hazard = 000, if_write = 1, pc_write = 1.
- Reset asserted mid-stall or mid-halt clears the state. After release, normal evaluation resumes on the same cycle.
- Stall together with a taken branch: the stall wins and the flush is suppressed. The branch re-resolves on the next cycle.

## Test plan
- No load: mem_read = F, op2_ex = F, op1 = F, op2 = C, op_code = 0, branch = 00 -> hazard = 000, if_write = 1, pc_write = 1. Repeat with mem_read = 0, op2_ex = 5, op2 = A -> same result.
- Load-use stall: mem_read = 1, op2_ex = F, op1 = F, op_code = 0 -> hazard = 001 and if_write = pc_write = 0 for one cycle. With the inputs held, the next cycle gives hazard = 000. Check that op2_ex = 0 never stalls, and that op2 = op2_ex with op_code = 4'h4 (op2 unused) does not stall.
- Branch flush: branch = 01 or 10 with no stall -> hazard = 010, if_write = pc_write = 1. With branch = 01 and a load-use dependency present at the same time -> hazard = 001 only.
- Halt: op_code = F -> hazard = 100 immediately. After the clock edge, op_code = 0 still gives hazard = 100 and if_write = pc_write = 0 until rst.
- Async reset: assert rst between clock edges while halted -> hazard = 000 and if_write = pc_write = 1 without waiting for a clock edge. After release, normal behaviour resumes.
